// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests feeding an in-order queue toward decode.
// Optional FETCH_CNT_EN adds the fetch_count port (instructions popped to decode).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        halt
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  logic [31:0] pcReg;
  logic [31:0] redirPc;
  logic        dropPending;
  logic        stopFetch;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [31:0]      instrQ [QDEPTH];
  logic [31:0]      pc4Q   [QDEPTH];

  logic [31:0] redirTarget;
  logic [31:0] headInstr;
  logic        redirTake;
  logic        memAccept;
  logic        pushEn;
  logic        popEn;
  logic        haltPop;
  logic        headIsEnd;
  logic        rdataIsEnd;
  logic        canIssue;
  logic        qNotEmpty;

  assign redirTarget = redirect_pc & ALIGN_MASK;
  assign redirTake   = redirect_valid && (state != HALTED);
  assign qNotEmpty   = (count != '0);
  assign headInstr   = instrQ[rdPtr];
  assign headIsEnd   = (headInstr[31:26] == 6'h3F) && (headInstr[5:0] == 6'h3F);
  assign rdataIsEnd  = (imem_rdata[31:26] == 6'h3F) && (imem_rdata[5:0] == 6'h3F);
  assign canIssue    = !stopFetch && (count < CNT_W'(QDEPTH));

  // A redirect in the same cycle beats both an arriving response and a pop.
  assign memAccept = imem_req && imem_ack;
  assign pushEn    = memAccept && !dropPending && !redirTake;
  assign popEn     = qNotEmpty && id_ready && !redirTake;
  assign haltPop   = popEn && headIsEnd;

  assign imem_addr = pcReg;
  assign id_valid  = qNotEmpty;
  assign id_instr  = qNotEmpty ? headInstr : 32'h0;
  assign id_pc4    = qNotEmpty ? pc4Q[rdPtr] : 32'h0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (haltPop) begin
          nextState = HALTED;
        end else if (imem_req && !imem_ack) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (haltPop) begin
          nextState = HALTED;
        end else if (imem_ack) begin
          nextState = IDLE;
        end
      end
      HALTED:  nextState = HALTED;
      default: nextState = IDLE;
    endcase
  end

  // Output decode; request is presented in IDLE as soon as space allows
  always_comb begin
    imem_req = 1'b0;
    halt     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    imem_req = canIssue;
        WAIT:    imem_req = 1'b1;
        HALTED:  halt     = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  // Fetch pc; a redirect against a presented request is parked until that request is acked
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg       <= RESET_PC & ALIGN_MASK;
      redirPc     <= RESET_PC & ALIGN_MASK;
      dropPending <= 1'b0;
    end else if (memAccept) begin
      dropPending <= 1'b0;
      if (redirTake) begin
        pcReg <= redirTarget;
      end else if (dropPending) begin
        pcReg <= redirPc;
      end else begin
        pcReg <= pcReg + 32'd4;
      end
    end else if (redirTake) begin
      if (imem_req) begin
        dropPending <= 1'b1;
        redirPc     <= redirTarget;
      end else begin
        pcReg <= redirTarget;
      end
    end
  end

  // Stop issuing once the end word is queued; a redirect discards it and resumes
  always_ff @(posedge clk) begin
    if (reset) begin
      stopFetch <= 1'b0;
    end else if (redirTake) begin
      stopFetch <= 1'b0;
    end else if (pushEn && rdataIsEnd) begin
      stopFetch <= 1'b1;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (redirTake || haltPop) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(pushEn) - CNT_W'(popEn);
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (pushEn) begin
      instrQ[wrPtr] <= imem_rdata;
      pc4Q[wrPtr]   <= pcReg + 32'd4;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] fetchCnt;

  // Counts accepted pops only; flushed entries never reach decode
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCnt <= 32'h0;
    end else if (popEn) begin
      fetchCnt <= fetchCnt + 32'd1;
    end
  end

  assign fetch_count = fetchCnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run scored against an
// in-order address-stream model (next delivered pc, reset by redirects).
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 4;
  localparam logic [31:0] END_WORD = 32'hFC00_003F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        halt;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int total = 0;
  int bad = 0;

  int          memLatency = 0;
  int          memWait = 0;
  bit          forceAck = 1'b0;
  bit          endEnable = 1'b0;
  logic [31:0] endAddr = 32'h0;

  int          ackSeen;
  bit          pendSeen;
  logic [31:0] pendAddr;
  logic [31:0] maxReqAddr;

  logic [31:0] expPc;
  logic [31:0] tgt;
  logic [31:0] r;
  bit          doRedir;
  bit          redirPrev;
  bit          found;
  int          pops;

  fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc4(id_pc4),
    .halt(halt)
`ifdef FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Program image: bits[1:0]=01 keeps every ordinary word clear of the end pattern
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (endEnable && a == endAddr) return END_WORD;
    return ((a * 32'h9E37_79B1) & 32'hFFFF_FFFC) | 32'h1;
  endfunction

  // Memory: acks after memLatency idle cycles of a held request (0 = same cycle)
  always @(negedge clk) begin
    if (forceAck) begin
      imem_ack   = 1'b1;
      imem_rdata = memWord(imem_addr);
      memWait    = 0;
    end else if (imem_req) begin
      if (memWait >= memLatency) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        memWait    = 0;
      end else begin
        imem_ack = 1'b0;
        memWait++;
      end
    end else begin
      imem_ack = 1'b0;
      memWait  = 0;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: observe the memory handshake mid-cycle, return just after the rising edge
  task automatic step();
    @(negedge clk);
    #1;
    if (imem_req && imem_addr > maxReqAddr) maxReqAddr = imem_addr;
    if (imem_req && imem_ack) ackSeen++;
    pendSeen = imem_req && !imem_ack && !reset;
    pendAddr = imem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    forceAck = 1'b0;
    step();
    step();
    check1("rst_req", imem_req, 1'b0);
    check32("rst_addr", imem_addr, RESET_PC);
    check1("rst_valid", id_valid, 1'b0);
    check32("rst_instr", id_instr, 32'h0);
    check32("rst_pc4", id_pc4, 32'h0);
    check1("rst_halt", halt, 1'b0);
`ifdef FETCH_CNT_EN
    check32("rst_cnt", fetch_count, 32'h0);
`endif
    reset = 1'b0;
    #1;
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, RESET_PC);
    maxReqAddr = 32'h0;
    ackSeen = 0;
  endtask

  task automatic waitReqAddr(input logic [31:0] a, input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (imem_req && imem_addr == a) begin
        hit = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;

    // Zero-wait streaming: one address per cycle, pc4 = address + 4
    memLatency = 0;
    doReset();
    id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check1("stream_req", imem_req, 1'b1);
      check32("stream_addr", imem_addr, 32'(4 * k));
      check1("stream_valid", id_valid, 1'b1);
      check32("stream_pc4", id_pc4, 32'(4 * k));
      check32("stream_instr", id_instr, memWord(32'(4 * k - 4)));
    end

    // Back-pressure: queue fills with exactly QDEPTH words, one pop admits one more
    memLatency = 0;
    doReset();
    repeat (8) step();
    check32("full_acks", 32'(ackSeen), 32'(QDEPTH));
    check1("full_req", imem_req, 1'b0);
    check32("full_head", id_pc4, 32'h4);
    ackSeen = 0;
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    repeat (6) step();
    check32("refill_acks", 32'(ackSeen), 32'h1);
    check1("refill_req", imem_req, 1'b0);
    check32("refill_head", id_pc4, 32'h8);

    // Redirect while waiting on 0x8: that response is dropped, fetch resumes at 0x100
    memLatency = 3;
    doReset();
    id_ready = 1'b1;
    waitReqAddr(32'h8, 40, found);
    check1("reach_8", found, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    check1("redir_flush", id_valid, 1'b0);
    check1("redir_hold_req", imem_req, 1'b1);
    check32("redir_hold_addr", imem_addr, 32'h8);
    for (int i = 0; i < 20 && imem_addr == 32'h8; i++) step();
    check32("redir_next_addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && !id_valid; i++) step();
    check1("redir_deliver", id_valid, 1'b1);
    check32("redir_pc4", id_pc4, 32'h104);
    check32("redir_instr", id_instr, memWord(32'h100));

    // End word at 0x10: fetch stops there, halt follows its pop, redirect then ignored
    endEnable = 1'b1;
    endAddr = 32'h10;
    memLatency = 0;
    doReset();
    id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (id_valid && id_instr === END_WORD) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check1("end_seen", found, 1'b1);
    check1("end_no_halt_yet", halt, 1'b0);
    step();
    check1("end_halt", halt, 1'b1);
    check1("end_req", imem_req, 1'b0);
    check1("end_valid", id_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    check1("halt_sticky", halt, 1'b1);
    check1("halt_req", imem_req, 1'b0);
    check32("end_max_addr", maxReqAddr, 32'h10);
    endEnable = 1'b0;

    // Reset during WAIT with a coincident ack
    memLatency = 1;
    doReset();
    waitReqAddr(32'h8, 40, found);
    check1("reach_8b", found, 1'b1);
    step();
    reset = 1'b1;
    forceAck = 1'b1;
    step();
    forceAck = 1'b0;
    check1("midrst_valid", id_valid, 1'b0);
    check32("midrst_addr", imem_addr, RESET_PC);
    check1("midrst_req", imem_req, 1'b0);
    reset = 1'b0;
    #1;
    check1("midrst_reissue", imem_req, 1'b1);
    check32("midrst_readdr", imem_addr, RESET_PC);

    // Unaligned redirect near the top of the address space wraps to 0
    memLatency = 0;
    doReset();
    id_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    step();
    redirect_valid = 1'b0;
    check1("wrap_flush", id_valid, 1'b0);
    check32("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    check32("wrap_pc4_a", id_pc4, 32'hFFFF_FFFC);
    check32("wrap_instr_a", id_instr, memWord(32'hFFFF_FFF8));
    step();
    check32("wrap_pc4_b", id_pc4, 32'h0);
    check32("wrap_instr_b", id_instr, memWord(32'hFFFF_FFFC));
    step();
    check32("wrap_pc4_c", id_pc4, 32'h4);

`ifdef FETCH_CNT_EN
    // Five pops, then a redirect discarding two queued entries
    memLatency = 0;
    doReset();
    id_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 30 && pops < 5; i++) begin
      if (id_valid && id_ready) pops++;
      step();
    end
    id_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check1("cnt_flush", id_valid, 1'b0);
    check32("cnt_value", fetch_count, 32'h5);
`endif

    // Random run: delivered stream must follow the in-order pc model
    memLatency = 0;
    doReset();
    expPc = RESET_PC;
    pops = 0;
    redirPrev = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (redirPrev) check1("rnd_flush", id_valid, 1'b0);
      check32("rnd_align", imem_addr & 32'h3, 32'h0);
      check1("rnd_halt", halt, 1'b0);
      if (pendSeen) begin
        check1("rnd_req_hold", imem_req, 1'b1);
        check32("rnd_addr_hold", imem_addr, pendAddr);
      end
`ifdef FETCH_CNT_EN
      check32("rnd_cnt", fetch_count, 32'(pops));
`endif
      memLatency = int'($urandom_range(0, 3));
      id_ready = 1'($urandom_range(0, 1));
      doRedir = ($urandom_range(0, 19) == 0);
      if (doRedir) begin
        r = $urandom;
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (r & 32'hF)) : (r & 32'h0000_FFFF);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
      end else begin
        redirect_valid = 1'b0;
      end
      if (id_valid && id_ready && !doRedir) begin
        check32("rnd_pc4", id_pc4, expPc + 32'd4);
        check32("rnd_instr", id_instr, memWord(expPc));
        expPc = expPc + 32'd4;
        pops++;
      end
      if (doRedir) expPc = tgt & 32'hFFFF_FFFC;
      redirPrev = doRedir;
      step();
    end
    redirect_valid = 1'b0;
    check1("rnd_progress", pops >= 50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
